// File: rtl/pll_reset_pkg.sv
// Shared state encoding, default timing constants and helpers for the
// PLL reset sequencer.
package pll_reset_pkg;

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        HOLD      = 3'd3,
        RUN       = 3'd4,
        FAULT     = 3'd5
    } state_e;

    localparam int DEF_LOCK_STABLE_CYCLES  = 32'd1024;
    localparam int DEF_LOCK_TIMEOUT_CYCLES = 32'd65536;
    localparam int DEF_PLL_RST_CYCLES      = 32'd16;
    localparam int DEF_RST_HOLD_CYCLES     = 32'd32;
    localparam int DEF_MAX_RETRIES         = 32'd3;
    localparam int DEF_CNT_W               = 32'd17;

    localparam logic [7:0] LOCK_LOSS_MAX = 8'd255;

    // Saturating increment used for the lock-loss statistic.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        logic [7:0] r;
        if (v == LOCK_LOSS_MAX) begin
            r = v;
        end else begin
            r = v + 8'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/pll_reset_sequencer_if.sv
// Lock input and reset/status outputs of the PLL reset sequencer.
interface pll_reset_sequencer_if;
    import pll_reset_pkg::*;

    logic       locked;
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic       fault;
    logic [1:0] retry_cnt;
    logic [7:0] lock_loss_cnt;

    modport master (
        input  locked,
        output pll_rst,
        output sys_rst,
        output ready,
        output fault,
        output retry_cnt,
        output lock_loss_cnt
    );

    modport slave (
        output locked,
        input  pll_rst,
        input  sys_rst,
        input  ready,
        input  fault,
        input  retry_cnt,
        input  lock_loss_cnt
    );
endinterface

// File: rtl/bit_sync.sv
// Two-flop synchronizer with synchronous active-high reset to 0.
module bit_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta_q;
    logic meta_d;
    logic sync_q;
    logic sync_d;

    // Next values of the two synchronizer stages.
    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    // Synchronizer stage registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;
endmodule

// File: rtl/pll_reset_sequencer.sv
// Drives the PLL reset, qualifies lock and sequences the system reset;
// retries PLL reset on lock timeout and parks in FAULT when out of retries.
module pll_reset_sequencer
    import pll_reset_pkg::*;
#(
    parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
    parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
    parameter int PLL_RST_CYCLES      = DEF_PLL_RST_CYCLES,
    parameter int RST_HOLD_CYCLES     = DEF_RST_HOLD_CYCLES,
    parameter int MAX_RETRIES         = DEF_MAX_RETRIES,
    parameter int CNT_W               = DEF_CNT_W
) (
    input  logic                  refclk,
    input  logic                  rst,
    pll_reset_sequencer_if.master bus
);
    localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RST_HOLD_CYCLES - 1);
    localparam logic [1:0]       RETRY_LIMIT  = 2'(MAX_RETRIES);

    logic             locked_s;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pll_rst_q, pll_rst_d;
    logic             sys_rst_q, sys_rst_d;
    logic             ready_q, ready_d;
    logic             fault_q, fault_d;
    logic [1:0]       retry_cnt_q, retry_cnt_d;
    logic [7:0]       lock_loss_cnt_q, lock_loss_cnt_d;

    bit_sync u_lock_sync (
        .clk (refclk),
        .rst (rst),
        .d   (bus.locked),
        .q   (locked_s)
    );

    // Next-state, counter and output decode; outputs follow the next state
    // so they change on the same edge as the transition.
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        retry_cnt_d     = retry_cnt_q;
        lock_loss_cnt_d = lock_loss_cnt_q;

        case (state_q)
            PLL_RST: begin
                if (cnt_q == PULSE_LAST) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT_LOCK: begin
                // Lock seen on the timeout cycle still takes priority.
                if (locked_s) begin
                    state_d = STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    cnt_d = '0;
                    if (retry_cnt_q == RETRY_LIMIT) begin
                        state_d = FAULT;
                    end else begin
                        state_d     = PLL_RST;
                        retry_cnt_d = retry_cnt_q + 2'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STABLE: begin
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HOLD: begin
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d     = RUN;
                    cnt_d       = '0;
                    retry_cnt_d = 2'd0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RUN: begin
                // A lock loss re-qualifies without pulsing the PLL reset.
                if (!locked_s) begin
                    state_d         = WAIT_LOCK;
                    cnt_d           = '0;
                    lock_loss_cnt_d = sat_inc8(lock_loss_cnt_q);
                end else begin
                    state_d = RUN;
                end
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d = PLL_RST;
                cnt_d   = '0;
            end
        endcase

        pll_rst_d = (state_d == PLL_RST) || (state_d == FAULT);
        sys_rst_d = (state_d != RUN);
        ready_d   = (state_d == RUN);
        fault_d   = (state_d == FAULT);
    end

    // State, counter and registered outputs.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q         <= PLL_RST;
            cnt_q           <= '0;
            pll_rst_q       <= 1'b1;
            sys_rst_q       <= 1'b1;
            ready_q         <= 1'b0;
            fault_q         <= 1'b0;
            retry_cnt_q     <= 2'd0;
            lock_loss_cnt_q <= 8'd0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            pll_rst_q       <= pll_rst_d;
            sys_rst_q       <= sys_rst_d;
            ready_q         <= ready_d;
            fault_q         <= fault_d;
            retry_cnt_q     <= retry_cnt_d;
            lock_loss_cnt_q <= lock_loss_cnt_d;
        end
    end

    assign bus.pll_rst       = pll_rst_q;
    assign bus.sys_rst       = sys_rst_q;
    assign bus.ready         = ready_q;
    assign bus.fault         = fault_q;
    assign bus.retry_cnt     = retry_cnt_q;
    assign bus.lock_loss_cnt = lock_loss_cnt_q;
endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench: directed scenarios plus random lock/reset activity,
// compared every cycle against a phase/streak model of the sequencer.
module tb_pll_reset_sequencer;
    localparam int LS = 8;
    localparam int T  = 64;
    localparam int P  = 4;
    localparam int H  = 4;
    localparam int MR = 2;

    localparam int M_PULSE = 0;
    localparam int M_ACQ   = 1;
    localparam int M_RUN   = 2;
    localparam int M_FAULT = 3;

    logic refclk;
    logic rst;

    pll_reset_sequencer_if bus ();

    pll_reset_sequencer #(
        .LOCK_STABLE_CYCLES  (LS),
        .LOCK_TIMEOUT_CYCLES (T),
        .PLL_RST_CYCLES      (P),
        .RST_HOLD_CYCLES     (H),
        .MAX_RETRIES         (MR),
        .CNT_W               (17)
    ) dut (
        .refclk (refclk),
        .rst    (rst),
        .bus    (bus)
    );

    initial begin
        refclk = 1'b0;
        forever #10 refclk = ~refclk;
    end

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: coarse phase plus counts of lock history.
    int m_mode, m_pulse_done, m_wait, m_streak, m_retries, m_losses;
    bit m_lk1, m_lk2;

    int edge_no = 0;
    int last_rst_edge = 0;
    int hi_run = 0;
    int lo_run = 0;
    int last_gap = 0;
    bit rise_flag = 1'b0;
    bit prev_pll = 1'b1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed %0d (0x%0h) expected %0d (0x%0h) at edge %0d",
                     tag, obs, obs, exp, exp, edge_no);
        end
    endtask

    task automatic model_edge(input bit rst_in, input bit locked_in);
        bit ls;
        if (rst_in) begin
            m_mode = M_PULSE; m_pulse_done = 0; m_wait = 0; m_streak = 0;
            m_retries = 0; m_losses = 0; m_lk1 = 1'b0; m_lk2 = 1'b0;
        end else begin
            ls = m_lk2;
            m_lk2 = m_lk1;
            m_lk1 = locked_in;
            case (m_mode)
                M_PULSE: begin
                    m_pulse_done++;
                    if (m_pulse_done == P) begin
                        m_mode = M_ACQ; m_wait = 0; m_streak = 0;
                    end
                end
                M_ACQ: begin
                    if (ls) begin
                        m_streak++;
                        if (m_streak == 1 + LS + H) begin
                            m_mode = M_RUN; m_retries = 0;
                        end
                    end else if (m_streak > 0) begin
                        m_streak = 0; m_wait = 0;
                    end else if (m_wait == T - 1) begin
                        if (m_retries == MR) begin
                            m_mode = M_FAULT;
                        end else begin
                            m_retries++; m_mode = M_PULSE; m_pulse_done = 0;
                        end
                    end else begin
                        m_wait++;
                    end
                end
                M_RUN: begin
                    if (!ls) begin
                        m_mode = M_ACQ; m_streak = 0; m_wait = 0;
                        if (m_losses < 255) m_losses++;
                    end
                end
                default: ;
            endcase
        end
    endtask

    function automatic logic [13:0] model_outs();
        logic [13:0] v;
        v[13]  = (m_mode == M_PULSE) || (m_mode == M_FAULT);
        v[12]  = (m_mode != M_RUN);
        v[11]  = (m_mode == M_RUN);
        v[10]  = (m_mode == M_FAULT);
        v[9:8] = 2'(m_retries);
        v[7:0] = 8'(m_losses);
        return v;
    endfunction

    function automatic logic [13:0] dut_outs();
        return {bus.pll_rst, bus.sys_rst, bus.ready, bus.fault, bus.retry_cnt, bus.lock_loss_cnt};
    endfunction

    // One clock edge: advance the model, then compare all outputs.
    task automatic step();
        bit rst_smp;
        @(posedge refclk);
        rst_smp = rst;
        model_edge(rst, bus.locked);
        edge_no++;
        #1;
        check_eq("outs", 32'(dut_outs()), 32'(model_outs()));
        rise_flag = 1'b0;
        if (rst_smp) begin
            last_rst_edge = edge_no;
            hi_run = 1;
            lo_run = 0;
        end else if (bus.pll_rst === 1'b1) begin
            if (!prev_pll) begin
                rise_flag = 1'b1;
                last_gap = lo_run;
            end
            hi_run++;
            lo_run = 0;
        end else begin
            if (hi_run > 0) check_eq("pll_rst_width", 32'(hi_run), 32'(P));
            hi_run = 0;
            lo_run++;
        end
        prev_pll = (bus.pll_rst === 1'b1);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) step();
        rst = 1'b0;
    endtask

    task automatic wait_ready(input int start, input int exp_lat, input string tag);
        int n = 0;
        while (bus.ready !== 1'b1 && n < 300) begin
            step();
            n++;
        end
        check_eq({tag, "_ready"}, 32'(bus.ready), 32'd1);
        if (bus.ready === 1'b1) check_eq({tag, "_latency"}, 32'(edge_no - start), 32'(exp_lat));
    endtask

    initial begin
        int k;
        int n_retry;
        int n;
        int drop_len;

        rst = 1'b1;
        bus.locked = 1'b0;

        // Reset state and clean boot.
        do_reset(3);
        check_eq("reset_outs", 32'(dut_outs()), 32'h3000);
        repeat (10) step();
        bus.locked = 1'b1;
        k = edge_no + 1;
        wait_ready(k, 2 + LS + H, "boot");
        check_eq("boot_retry_cnt", 32'(bus.retry_cnt), 32'd0);
        check_eq("boot_sys_rst", 32'(bus.sys_rst), 32'd0);

        // One-cycle lock glitch during STABLE restarts qualification.
        bus.locked = 1'b0;
        do_reset(2);
        repeat (6) step();
        bus.locked = 1'b1;
        repeat (7) step();
        bus.locked = 1'b0;
        step();
        bus.locked = 1'b1;
        k = edge_no + 1;
        check_eq("glitch_no_ready", 32'(bus.ready), 32'd0);
        wait_ready(k, 2 + LS + H, "glitch");

        // Timeout retries: two retry pulses spaced by the timeout, then lock.
        bus.locked = 1'b0;
        do_reset(2);
        n_retry = 0;
        for (int i = 0; i < 2 * (P + T) + P; i++) begin
            step();
            if (rise_flag) begin
                n_retry++;
                check_eq("retry_gap", 32'(last_gap), 32'(T));
                check_eq("retry_cnt_step", 32'(bus.retry_cnt), 32'(n_retry));
            end
        end
        check_eq("retries_seen", 32'(n_retry), 32'd2);
        bus.locked = 1'b1;
        k = edge_no + 1;
        wait_ready(k, 2 + LS + H, "retry");
        check_eq("retry_cleared", 32'(bus.retry_cnt), 32'd0);

        // Retry budget exhausted: FAULT, ignores lock, cleared only by rst.
        bus.locked = 1'b0;
        do_reset(2);
        n = 0;
        while (bus.fault !== 1'b1 && n < 400) begin
            step();
            n++;
        end
        check_eq("fault_set", 32'(bus.fault), 32'd1);
        check_eq("fault_time", 32'(edge_no - last_rst_edge), 32'((MR + 1) * (P + T)));
        bus.locked = 1'b1;
        repeat (30) step();
        check_eq("fault_sticky", 32'({bus.fault, bus.pll_rst, bus.sys_rst, bus.ready}), 32'b1110);
        do_reset(1);
        check_eq("fault_cleared", 32'(dut_outs()), 32'h3000);

        // Boot with lock already present, then repeated lock loss in RUN.
        wait_ready(last_rst_edge, P + 1 + LS + H, "preboot");
        for (int it = 0; it < 260; it++) begin
            repeat ($urandom_range(0, 5)) step();
            drop_len = $urandom_range(1, 3);
            bus.locked = 1'b0;
            k = 0;
            for (int i = 1; i <= 3; i++) begin
                step();
                if (i == drop_len) begin
                    bus.locked = 1'b1;
                    k = edge_no + 1;
                end
                if (i == 2) check_eq("loss_k1_sys_rst", 32'(bus.sys_rst), 32'd0);
                if (i == 3) check_eq("loss_k2_sys_rst", 32'(bus.sys_rst), 32'd1);
            end
            if (it == 0) check_eq("loss_cnt_first", 32'(bus.lock_loss_cnt), 32'd1);
            wait_ready(k, 2 + LS + H, "requal");
        end
        check_eq("loss_cnt_sat", 32'(bus.lock_loss_cnt), 32'd255);

        // rst while in HOLD returns reset values and restarts the pulse.
        do_reset(1);
        wait_ready(last_rst_edge, P + 1 + LS + H, "prehold");
        bus.locked = 1'b0;
        do_reset(1);
        repeat (6) step();
        bus.locked = 1'b1;
        repeat (2 + LS + 2) step();
        check_eq("hold_no_ready", 32'(bus.ready), 32'd0);
        do_reset(1);
        check_eq("hold_rst_outs", 32'(dut_outs()), 32'h3000);
        wait_ready(last_rst_edge, P + 1 + LS + H, "after_hold_rst");

        // Random lock activity with occasional resets, model-checked.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) bus.locked = ~bus.locked;
            rst = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
